// File: rtl/counter_sum_accum.sv
// Streaming accumulator behind the column counters: reduces each beat's 4-bit lanes to one sum,
// accumulates beats per frame and presents a saturated total, beat count and overflow flag.
module counter_sum_accum #(
    parameter int unsigned LANES = 4,
    parameter int unsigned ACC_W = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_last,
    input  logic [4*LANES-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_sum,
    output logic [CNT_W-1:0]   out_beats,
    output logic               out_ovf
);

    localparam int unsigned S1_W = $clog2(15 * LANES + 1);

    logic             s1_valid_q, s1_valid_d;
    logic             s1_last_q, s1_last_d;
    logic [S1_W-1:0]  s1_sum_q, s1_sum_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] beats_q, beats_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic [CNT_W-1:0] out_beats_q, out_beats_d;
    logic             out_ovf_q, out_ovf_d;

    logic [S1_W-1:0]  lane_sum;
    logic             s2_free;
    logic             s1_move;
    logic             in_xfer;
    logic [ACC_W:0]   acc_ext;
    logic             carry;
    logic [ACC_W-1:0] acc_sat;
    logic [CNT_W-1:0] beats_inc;

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + S1_W'(in_data[4*i +: 4]);
        end
    end

    // Non-last beats keep accumulating while a result is held; only a last beat waits for the
    // output register to free up.
    assign s2_free  = !out_valid_q || out_ready;
    assign s1_move  = s1_valid_q && (!s1_last_q || s2_free);
    assign in_ready = !s1_valid_q || !s1_last_q || s2_free;
    assign in_xfer  = in_valid && in_ready;

    assign acc_ext   = {1'b0, acc_q} + (ACC_W + 1)'(s1_sum_q);
    assign carry     = acc_ext[ACC_W];
    assign acc_sat   = carry ? '1 : acc_ext[ACC_W-1:0];
    assign beats_inc = (&beats_q) ? beats_q : beats_q + CNT_W'(1);

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_last_d   = s1_last_q;
        s1_sum_d    = s1_sum_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        beats_d     = beats_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_beats_d = out_beats_q;
        out_ovf_d   = out_ovf_q;

        if (in_xfer) begin
            s1_valid_d = 1'b1;
            s1_last_d  = in_last;
            s1_sum_d   = lane_sum;
        end else if (s1_move) begin
            s1_valid_d = 1'b0;
        end

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (s1_move) begin
            if (s1_last_q) begin
                out_sum_d   = acc_sat;
                out_ovf_d   = ovf_q | carry;
                out_beats_d = beats_inc;
                out_valid_d = 1'b1;
                acc_d       = '0;
                ovf_d       = 1'b0;
                beats_d     = '0;
            end else begin
                acc_d   = acc_sat;
                ovf_d   = ovf_q | carry;
                beats_d = beats_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_sum_q    <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            beats_q     <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_beats_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_sum_q    <= s1_sum_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            beats_q     <= beats_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_beats_q <= out_beats_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_beats = out_beats_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_counter_sum_accum.sv
// Bench for counter_sum_accum: directed frames, a table of single-beat frames and a random
// regression, all checked against a behavioural frame model through a result queue.
module tb_counter_sum_accum;

    localparam int unsigned LANES = 4;
    localparam int unsigned ACC_W = 8;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned DW    = 4 * LANES;
    localparam int          AMAX  = (1 << ACC_W) - 1;
    localparam int          BMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             in_last;
    logic [DW-1:0]    in_data;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_beats;
    logic             out_ovf;

    always #5 clk = ~clk;

    counter_sum_accum #(
        .LANES(LANES),
        .ACC_W(ACC_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_last  (in_last),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_beats(out_beats),
        .out_ovf  (out_ovf)
    );

    typedef struct {
        int sum;
        int beats;
        int ovf;
        int cyc;
    } res_t;

    typedef struct {
        logic [DW-1:0] data;
        int            sum;
    } vec_t;

    res_t exp_q[$];
    res_t log_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   m_acc;
    int   m_beats;
    int   m_ovf;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int lane_total(input logic [DW-1:0] d);
        int t = 0;
        for (int i = 0; i < LANES; i++) t += int'(d[4*i +: 4]);
        return t;
    endfunction

    task automatic model_clear();
        m_acc   = 0;
        m_beats = 0;
        m_ovf   = 0;
        exp_q.delete();
    endtask

    task automatic model_accept(input logic [DW-1:0] d, input logic l);
        res_t r;
        int   s = lane_total(d);
        if (m_acc + s > AMAX) begin
            m_acc = AMAX;
            m_ovf = 1;
        end else begin
            m_acc = m_acc + s;
        end
        if (m_beats < BMAX) m_beats++;
        if (l) begin
            r.sum   = m_acc;
            r.beats = m_beats;
            r.ovf   = m_ovf;
            r.cyc   = 0;
            exp_q.push_back(r);
            m_acc   = 0;
            m_beats = 0;
            m_ovf   = 0;
        end
    endtask

    // Presents one beat until accepted; returns #1 after the accepting edge with in_valid low.
    task automatic send(input logic [DW-1:0] d, input logic l, output int waits);
        bit done = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        waits    = 0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1;
            end else begin
                waits++;
                if (waits > 50) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout: in_ready low for %0d cycles, expected accept", waits);
                    done = 1;
                end
            end
        end
        if (waits <= 50) begin
            model_accept(d, l);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_sum"}, out_sum, 0);
        check({tag, "_out_beats"}, out_beats, 0);
        check({tag, "_out_ovf"}, out_ovf, 0);
    endtask

    task automatic check_log(input string tag, input int idx, input int sum, input int beats,
                             input int ovf);
        if (idx < log_q.size()) begin
            check({tag, "_sum"}, log_q[idx].sum, sum);
            check({tag, "_beats"}, log_q[idx].beats, beats);
            check({tag, "_ovf"}, log_q[idx].ovf, ovf);
        end else begin
            checks++;
            errors++;
            $display("FAIL %s_missing: got %0d results expected more than %0d", tag, log_q.size(),
                     idx);
        end
    endtask

    // Output monitor: scoreboard on every output transfer, payload stability while held.
    initial begin
        res_t r;
        res_t e;
        res_t prev;
        bit   prev_hold = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_hold = 0;
            end else begin
                if (prev_hold) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_sum", out_sum, prev.sum);
                    check("hold_beats", out_beats, prev.beats);
                    check("hold_ovf", out_ovf, prev.ovf);
                end
                r.sum   = int'(out_sum);
                r.beats = int'(out_beats);
                r.ovf   = int'(out_ovf);
                r.cyc   = cyc;
                if (out_valid && out_ready) begin
                    log_q.push_back(r);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected: got result sum %0d with no frame pending",
                                 r.sum);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_sum", out_sum, e.sum);
                        check("sb_beats", out_beats, e.beats);
                        check("sb_ovf", out_ovf, e.ovf);
                    end
                end
                prev_hold = out_valid && !out_ready;
                prev      = r;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        int   w;
        int   maxw;
        int   accepted;
        int   guard;

        tbl[0] = '{data: 16'h0005, sum: 5};
        tbl[1] = '{data: 16'h0090, sum: 9};
        tbl[2] = '{data: 16'h0000, sum: 0};
        tbl[3] = '{data: 16'hFFFF, sum: 60};
        tbl[4] = '{data: 16'h8421, sum: 15};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Three-beat frame and result latency.
        send(16'hFFFF, 1'b0, w);
        send(16'h4321, 1'b0, w);
        send(16'h7000, 1'b1, w);
        @(negedge clk);
        check("lat_early_valid", out_valid, 0);
        @(negedge clk);
        check("lat_valid", out_valid, 1);
        check("f1_sum", out_sum, 77);
        check("f1_beats", out_beats, 3);
        check("f1_ovf", out_ovf, 0);
        @(posedge clk);
        #1;

        // Back-to-back single-beat frames from the table.
        log_q.delete();
        maxw = 0;
        for (int i = 0; i < 5; i++) begin
            send(tbl[i].data, 1'b1, w);
            if (w > maxw) maxw = w;
        end
        repeat (3) @(posedge clk);
        #1;
        check("b2b_in_ready_waits", maxw, 0);
        check("b2b_count", log_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check_log("b2b", i, tbl[i].sum, 1, 0);
            if (i > 0 && i < log_q.size()) begin
                check("b2b_spacing", log_q[i].cyc - log_q[i-1].cyc, 1);
            end
        end

        // Backpressure: held result, two non-last beats accepted, last beat stalls in S1.
        log_q.delete();
        out_ready = 1'b0;
        send(16'h0003, 1'b1, w);
        send(16'h0011, 1'b0, w);
        check("bp_nonlast0_waits", w, 0);
        send(16'h0022, 1'b0, w);
        check("bp_nonlast1_waits", w, 0);
        send(16'h0033, 1'b1, w);
        check("bp_last_waits", w, 0);
        @(negedge clk);
        check("bp_in_ready", in_ready, 0);
        check("bp_held_valid", out_valid, 1);
        check("bp_held_sum", out_sum, 3);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("bp_count", log_q.size(), 2);
        check_log("bp_first", 0, 3, 1, 0);
        check_log("bp_second", 1, 12, 3, 0);
        if (log_q.size() == 2) check("bp_spacing", log_q[1].cyc - log_q[0].cyc, 1);

        // Saturation then a clean following frame.
        log_q.delete();
        for (int i = 0; i < 5; i++) send(16'hFFFF, (i == 4), w);
        send(16'h0001, 1'b1, w);
        repeat (3) @(posedge clk);
        #1;
        check("sat_count", log_q.size(), 2);
        check_log("sat", 0, 255, 5, 1);
        check_log("after_sat", 1, 1, 1, 0);

        // Asynchronous reset in the middle of a frame.
        log_q.delete();
        send(16'h000A, 1'b0, w);
        send(16'h000A, 1'b0, w);
        #1;
        rst_n = 1'b0;
        model_clear();
        #1;
        check_reset_outputs("mid_rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(16'h0003, 1'b1, w);
        repeat (3) @(posedge clk);
        #1;
        check("rst_count", log_q.size(), 1);
        check_log("rst_next", 0, 3, 1, 0);

        // Random regression.
        accepted = 0;
        guard    = 0;
        while (accepted < 10000 && guard < 60000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = DW'($urandom);
            if ($urandom_range(0, 7) == 0) in_data = '0;
            in_last   = ($urandom_range(0, 9) == 0);
            @(negedge clk);
            if (in_valid && in_ready) begin
                model_accept(in_data, in_last);
                accepted++;
            end
            guard++;
            @(posedge clk);
            #1;
        end
        if (accepted < 10000) begin
            checks++;
            errors++;
            $display("FAIL rand_progress: got %0d beats accepted expected 10000", accepted);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("rand_no_lost", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
